// File: rtl/md_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add multiply and
// restoring divide over 32 iterations plus a sign-fix cycle, owning HI/LO.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int CALC_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(CALC_CYCLES);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             idle_go, is_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_rem;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Any accepted request needs an idle unit and no squash in the same cycle.
  assign idle_go   = start && !flush && (state_q == S_IDLE);
  assign is_signed = !MDOp[0];
  assign neg_a     = is_signed && A[WIDTH-1];
  assign neg_b     = is_signed && B[WIDTH-1];
  assign mag_a     = neg_a ? -A : A;
  assign mag_b     = neg_b ? -B : B;

  // Multiply: multiplier bits leave LO from the bottom while product bits enter HI.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
  // Divide: dividend bits enter the partial remainder from LO's top.
  assign div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opb_q};
  assign div_rem = div_sh - {1'b0, opb_q};

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  // A zero divisor leaves |A| as the remainder, so sign-restoring it yields A.
  assign quo_fix  = dz_q ? '1 : ((sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q);
  assign rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (idle_go && !MDOp[2]) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          op_d     = MDOp[1:0];
          sa_d     = neg_a;
          sb_d     = neg_b;
          dz_d     = (B == '0);
          acc_hi_d = '0;
          acc_lo_d = mag_a;
          opb_d    = mag_b;
        end else if (idle_go && MDOp == 3'd4) begin
          hi_d = A;
        end else if (idle_go && MDOp == 3'd5) begin
          lo_d = A;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            acc_hi_d = div_ge ? div_rem[WIDTH-1:0] : div_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(CALC_CYCLES - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {HI,LO} queued at launch, popped on done.
module tb_md_unit;
  logic        clk = 1'b0, rst, start = 1'b0, flush = 1'b0;
  logic [2:0]  MDOp = '0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done;
  logic [31:0] HI, LO;

  int          n_cmp = 0, n_err = 0;
  logic [63:0] sb_q[$];
  logic        done_prev = 1'b0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .CALC_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op == 3'd0) return 64'(sa * sbv);
    if (op == 3'd1) return {32'b0, a} * {32'b0, b};
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (op == 3'd2) begin
      q = sa / sbv;
      r = sa % sbv;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      chk("done_width", {63'b0, done_prev}, 64'd0);
      if (sb_q.size() == 0) chk("spurious_done", {63'b0, done}, 64'd0);
      else chk("done_hilo", {HI, LO}, sb_q.pop_front());
    end
    done_prev <= done;
  end

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, bc;
    MDOp = op; A = a; B = b; start = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(bc), 64'd33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_flags", {62'b0, busy, done}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_ff");
    chk("multu_ff_k", {HI, LO}, 64'hFFFFFFFE_00000001);
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, "mult_neg");
    chk("mult_neg_k", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(3'd1, 32'hFFFFFFFD, 32'd7, "multu_big");
    chk("multu_big_k", {HI, LO}, 64'h00000006_FFFFFFEB);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
    chk("div_neg_k", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd3, 32'd100, 32'd7, "divu");
    chk("divu_k", {HI, LO}, 64'h00000002_0000000E);
    run_op(3'd3, 32'd5, 32'd0, "divu_z");
    chk("divu_z_k", {HI, LO}, 64'h00000005_FFFFFFFF);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    chk("div_ovf_k", {HI, LO}, 64'h00000000_80000000);
    run_op(3'd2, 32'hFFFFFFF9, 32'd0, "div_z");
    chk("div_z_k", {HI, LO}, 64'hFFFFFFF9_FFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = rb >> 27;
      if (i == 4) rb = 32'd0;
      run_op(3'($urandom_range(0, 3)), ra, rb, "rand");
    end

    @(negedge clk);
    MDOp = 3'd4; A = 32'h12345678; start = 1'b1;
    @(negedge clk);
    chk("mthi", {32'b0, HI}, {32'b0, 32'h12345678});
    chk("mthi_busy", {63'b0, busy}, 64'd0);
    MDOp = 3'd5; A = 32'h9ABCDEF0;
    @(negedge clk);
    chk("mtlo", {HI, LO}, 64'h12345678_9ABCDEF0);
    MDOp = 3'd6; A = 32'h0;
    @(negedge clk);
    MDOp = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("rsvd_hilo", {HI, LO}, 64'h12345678_9ABCDEF0);
    chk("rsvd_busy", {63'b0, busy}, 64'd0);

    // Flush mid-CALC with stray start pulses while busy.
    MDOp = 3'd0; A = 32'd3; B = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      if (c == 2) begin MDOp = 3'd4; A = 32'hDEADBEEF; end
      else begin MDOp = 3'd1; A = c; B = c; end
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_mid", {63'b0, busy}, 64'd1);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hilo", {HI, LO}, 64'h12345678_9ABCDEF0);
    repeat (40) @(negedge clk);
    chk("flush_idle", {31'b0, busy, HI}, {32'b0, 32'h12345678});

    // Flush together with start: start dropped.
    MDOp = 3'd2; A = 32'd50; B = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start", {63'b0, busy}, 64'd0);

    // Flush during FIX: no write, no done.
    MDOp = 3'd1; A = 32'd9; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    chk("fix_busy", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fix_flush_busy", {62'b0, busy, done}, 64'd0);
    chk("fix_flush_hilo", {HI, LO}, 64'h12345678_9ABCDEF0);

    // Asynchronous reset mid-CALC.
    MDOp = 3'd3; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_flags", {62'b0, busy, done}, 64'd0);
    chk("arst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(3'd1, 32'd2, 32'd3, "post_rst");
    chk("post_rst_k", {HI, LO}, 64'h00000000_00000006);

    @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
